// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and FSM state encoding for the data-memory arbiter.
//   DMEM_ADDR_W / DMEM_DATA_W : default word-address and data widths
//   DMEM_CNT_W                : width of the optional grant counters
//   state_e                   : sequencer states (2'd3 is illegal)
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 8;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage : dmem_pkg

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   valid_i[1:0] : request lines, bit N = requester N
//   last_i       : requester granted most recently
//   winner_c     : chosen requester (meaningful only when any_c=1)
//   any_c        : at least one request present
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       winner_c,
  output logic       any_c
);

  // A lone requester always wins; on contention the one not served last wins.
  always_comb begin
    any_c    = |valid_i;
    winner_c = valid_i[1];
    if (&valid_i) begin
      winner_c = ~last_i;
    end
  end

endmodule : rr_arb2

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and sequencer for the single-port data memory.
// Requester 0 is the CPU load/store unit, requester 1 the DMA/debug port.
// One transaction in flight: ready at T, memory strobe at T+1, rvalid/rdata at T+2.
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   rN_valid/we/addr/wdata  request from requester N (held until rN_ready)
//   rN_ready, rN_rvalid     accept pulse and completion pulse for requester N
//   rdata                   read data, valid with rN_rvalid of a read
//   mem_re/mem_wr/mem_addr/mem_wdata  memory strobes and payload
//   mem_rdata               memory read data, updated on negedge clk
// Build option: define DMEM_ARB_STATS_EN to add 16-bit per-requester grant
// counters gnt0_cnt/gnt1_cnt (cleared by reset, wrapping).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic              r0_rvalid,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_re,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [DMEM_CNT_W-1:0] gnt0_cnt,
  output logic [DMEM_CNT_W-1:0] gnt1_cnt
`endif
);

  // States name the step being launched at the next edge: IDLE grants,
  // ACCESS raises the strobe, RESP captures data and raises rvalid.
  state_e state_q, state_d;

  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              r0_ready_q, r0_ready_d;
  logic              r1_ready_q, r1_ready_d;
  logic              r0_rvalid_q, r0_rvalid_d;
  logic              r1_rvalid_q, r1_rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

`ifdef DMEM_ARB_STATS_EN
  logic [DMEM_CNT_W-1:0] gnt0_cnt_q, gnt0_cnt_d;
  logic [DMEM_CNT_W-1:0] gnt1_cnt_q, gnt1_cnt_d;
`endif

  logic pick_c;
  logic any_c;

  // Winner selection between the two requesters.
  rr_arb2 u_rr_arb2 (
    .valid_i  ({r1_valid, r0_valid}),
    .last_i   (last_q),
    .winner_c (pick_c),
    .any_c    (any_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    we_d        = we_q;
    r0_ready_d  = 1'b0;
    r1_ready_d  = 1'b0;
    r0_rvalid_d = 1'b0;
    r1_rvalid_d = 1'b0;
    rdata_d     = rdata_q;
    mem_re_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef DMEM_ARB_STATS_EN
    gnt0_cnt_d  = gnt0_cnt_q;
    gnt1_cnt_d  = gnt1_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (any_c) begin
          state_d    = ACCESS;
          last_d     = pick_c;
          win_d      = pick_c;
          r0_ready_d = ~pick_c;
          r1_ready_d = pick_c;
          if (pick_c) begin
            we_d        = r1_we;
            mem_addr_d  = r1_addr;
            mem_wdata_d = r1_wdata;
          end else begin
            we_d        = r0_we;
            mem_addr_d  = r0_addr;
            mem_wdata_d = r0_wdata;
          end
`ifdef DMEM_ARB_STATS_EN
          if (pick_c) begin
            gnt1_cnt_d = gnt1_cnt_q + DMEM_CNT_W'(1);
          end else begin
            gnt0_cnt_d = gnt0_cnt_q + DMEM_CNT_W'(1);
          end
`endif
        end
      end
      ACCESS: begin
        state_d  = RESP;
        mem_re_d = ~we_q;
        mem_wr_d = we_q;
      end
      RESP: begin
        // The memory acted on the negedge inside the strobe cycle.
        state_d     = IDLE;
        r0_rvalid_d = ~win_q;
        r1_rvalid_d = win_q;
        if (!we_q) begin
          rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      r0_ready_q  <= 1'b0;
      r1_ready_q  <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      rdata_q     <= '0;
      mem_re_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef DMEM_ARB_STATS_EN
      gnt0_cnt_q  <= '0;
      gnt1_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      we_q        <= we_d;
      r0_ready_q  <= r0_ready_d;
      r1_ready_q  <= r1_ready_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
      rdata_q     <= rdata_d;
      mem_re_q    <= mem_re_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef DMEM_ARB_STATS_EN
      gnt0_cnt_q  <= gnt0_cnt_d;
      gnt1_cnt_q  <= gnt1_cnt_d;
`endif
    end
  end

  assign r0_ready  = r0_ready_q;
  assign r1_ready  = r1_ready_q;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign rdata     = rdata_q;
  assign mem_re    = mem_re_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef DMEM_ARB_STATS_EN
  assign gnt0_cnt  = gnt0_cnt_q;
  assign gnt1_cnt  = gnt1_cnt_q;
`endif

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized bench for dmem_arbiter.
// A negedge memory model serves the DUT; a transaction-level reference
// (last grantee, shadow memory, last read value, grant counts) predicts results.
// Grant counters are checked when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int unsigned AW = DMEM_ADDR_W;
  localparam int unsigned DW = DMEM_DATA_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_valid, r0_we, r1_valid, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_ready, r0_rvalid, r1_ready, r1_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_re, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   gnt0_cnt, gnt1_cnt;
`endif

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0_valid  (r0_valid),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_ready  (r0_ready),
    .r0_rvalid (r0_rvalid),
    .r1_valid  (r1_valid),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_ready  (r1_ready),
    .r1_rvalid (r1_rvalid),
    .rdata     (rdata),
    .mem_re    (mem_re),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .gnt0_cnt  (gnt0_cnt),
    .gnt1_cnt  (gnt1_cnt)
`endif
  );

  // Environment memory: acts on the negedge while a strobe is high.
  logic [DW-1:0] env_mem [256];
  always @(negedge clk) begin
    if (mem_re) mem_rdata <= env_mem[mem_addr];
    if (mem_wr) env_mem[mem_addr] <= mem_wdata;
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [256];
  bit            last_m;
  logic [DW-1:0] rdata_m;
  logic [15:0]   cnt0_m, cnt1_m;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One arbitration round from an idle DUT: grant, strobe, response.
  task automatic do_round(output int win);
    bit            any_v, w;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    any_v = r0_valid | r1_valid;
    if (r0_valid && r1_valid) w = ~last_m;
    else                      w = r1_valid;
    tick();
    chk("ready0", r0_ready, any_v && !w);
    chk("ready1", r1_ready, any_v && w);
    if (!any_v) begin
      win = -1;
      return;
    end
    if (w) begin
      we = r1_we; a = r1_addr; d = r1_wdata; r1_valid = 1'b0;
      cnt1_m++;
    end else begin
      we = r0_we; a = r0_addr; d = r0_wdata; r0_valid = 1'b0;
      cnt0_m++;
    end
    last_m = w;
    tick();
    chk("strobe_re", mem_re, !we);
    chk("strobe_wr", mem_wr, we);
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, d);
    chk("ready_quiet", {r0_ready, r1_ready}, 2'b00);
    if (we) ref_mem[a] = d;
    else    rdata_m = ref_mem[a];
    tick();
    chk("rvalid0", r0_rvalid, !w);
    chk("rvalid1", r1_rvalid, w);
    chk("strobe_quiet", {mem_re, mem_wr}, 2'b00);
    chk("rdata", rdata, rdata_m);
    win = w;
  endtask

  task automatic model_reset();
    last_m  = 1'b1;
    rdata_m = '0;
    cnt0_m  = '0;
    cnt1_m  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = DW'(i);
      ref_mem[i] = DW'(i);
    end
    mem_rdata = '0;
    rst_n = 1'b0;
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;

    // Reset held two cycles with a pending request.
    tick();
    tick();
    chk("rst_ready", {r0_ready, r1_ready}, 2'b00);
    chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 2'b00);
    chk("rst_strobe", {mem_re, mem_wr}, 2'b00);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    r0_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // Single read of address 5.
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 8'h05;
    do_round(w);
    chk("t2_win", w, 0);
    chk("t2_rdata", rdata, 32'h5);

    // Write then read back on requester 1.
    r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 8'h10; r1_wdata = 32'hDEADBEEF;
    do_round(w);
    chk("t3_wr_win", w, 1);
    chk("t3_wr_rdata_hold", rdata, 32'h5);
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 8'h10;
    do_round(w);
    chk("t3_rd_rdata", rdata, 32'hDEADBEEF);

    // Contention: alternating grants starting with requester 0.
    for (int i = 0; i < 4; i++) begin
      if (!r0_valid) begin
        r0_valid = 1'b1; r0_we = 1'b0; r0_addr = AW'($urandom_range(31));
      end
      if (!r1_valid) begin
        r1_valid = 1'b1; r1_we = 1'b0; r1_addr = AW'($urandom_range(31));
      end
      do_round(w);
      chk("t4_order", w, i % 2);
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;

    // Reset during the strobe cycle of a read aborts the response.
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 8'h20;
    tick();
    chk("t5_ready", r0_ready, 1);
    r0_valid = 1'b0;
    tick();
    chk("t5_strobe", mem_re, 1);
    rst_n = 1'b0;
    tick();
    chk("t5_no_rvalid", {r0_rvalid, r1_rvalid}, 2'b00);
    chk("t5_rdata_clr", rdata, 0);
    chk("t5_strobe_clr", {mem_re, mem_wr}, 2'b00);
    rst_n = 1'b1;
    model_reset();
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 8'h21;
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 8'h22;
    do_round(w);
    chk("t5_idle_grant", w, 0);
    r1_valid = 1'b0;

    // Randomized traffic: pending losers are held or occasionally withdrawn.
    for (int i = 0; i < 60; i++) begin
      if (!r0_valid || $urandom_range(3) == 0) begin
        r0_valid = ($urandom_range(2) != 0);
        r0_we    = 1'($urandom_range(1));
        r0_addr  = AW'($urandom_range(15));
        r0_wdata = DW'($urandom);
      end
      if (!r1_valid || $urandom_range(3) == 0) begin
        r1_valid = ($urandom_range(2) != 0);
        r1_we    = 1'($urandom_range(1));
        r1_addr  = AW'($urandom_range(15));
        r1_wdata = DW'($urandom);
      end
      do_round(w);
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;

`ifdef DMEM_ARB_STATS_EN
    chk("cnt0", gnt0_cnt, cnt0_m);
    chk("cnt1", gnt1_cnt, cnt1_m);
    force dut.gnt0_cnt_q = 16'hFFFF;
    #1;
    release dut.gnt0_cnt_q;
    cnt0_m = 16'hFFFF;
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 8'h01;
    do_round(w);
    chk("cnt0_wrap", gnt0_cnt, 16'h0000);
    chk("cnt0_model", gnt0_cnt, cnt0_m);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dmem_arbiter
